// File: rtl/mux_scan_reg.sv
// Registered N-channel, W-bit selector with a validated direct-select handshake
// and a round-robin auto-scan mode that holds each channel for dwell+1 cycles.
module mux_scan_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL_W  = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic [WIDTH*CHANNELS-1:0] c,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_valid,
    input  logic                      scan_en,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_valid,
    output logic                      err
);

    localparam logic [SEL_W:0]   NUM_CH  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0]   ch;
    logic [SEL_W-1:0]   ch_next;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_next;
    logic               armed;
    logic               armed_next;
    logic               scan_q;
    logic               sel_in_range;
    logic               sel_ok;
    logic               sel_bad;

    // The zero-extended compare only rejects anything when CHANNELS is not a power of 2.
    assign sel_in_range = ({1'b0, sel} < NUM_CH);
    assign sel_ok       = sel_valid && sel_in_range;
    assign sel_bad      = sel_valid && !sel_in_range;

    always_comb begin
        ch_next    = ch;
        cnt_next   = cnt;
        armed_next = armed;
        if (scan_en) begin
            if (!scan_q) begin
                cnt_next   = '0;
                armed_next = 1'b1;
            end else if (cnt == dwell) begin
                cnt_next = '0;
                ch_next  = (ch == LAST_CH) ? '0 : ch + 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end else begin
            cnt_next = '0;
        end
        // An accepted select overrides whatever the scan would have done this cycle.
        if (sel_ok) begin
            ch_next    = sel;
            cnt_next   = '0;
            armed_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ch      <= '0;
            cnt     <= '0;
            armed   <= 1'b0;
            scan_q  <= 1'b0;
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            ch      <= ch_next;
            cnt     <= cnt_next;
            armed   <= armed_next;
            scan_q  <= scan_en;
            y       <= c[int'(ch)*WIDTH +: WIDTH];
            y_ch    <= ch;
            y_valid <= armed;
            err     <= sel_bad;
        end
    end

endmodule

// File: doc/mux_scan_reg.md
# mux_scan_reg

Parametrised, registered N-channel, W-bit selector: the clocked successor of the 4:1 single-bit data multiplexer. It adds a direct-select mode with a select handshake and a round-robin auto-scan mode with a programmable dwell time. Its output is registered and tagged with the channel it came from. It sits between the register file / input port and the ALU operand path, and also serves as a time-multiplexed display or probe scanner.

## Interface
Parameters:
- WIDTH, 4, bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- DWELL_W, 4, width of the dwell counter
- SEL_W, derived: $clog2(CHANNELS), select and channel-tag width

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- n_reset  in  1  asynchronous, active-low reset
- c  in  WIDTH*CHANNELS  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  requested channel
- sel_valid  in  1  sel is sampled on this cycle's edge
- scan_en  in  1  1 = auto-scan mode, 0 = direct mode
- dwell  in  DWELL_W  scan mode only: the channel is held dwell+1 cycles before advancing
- y  out  WIDTH  registered data of the selected channel
- y_ch  out  SEL_W  channel index that y was sampled from
- y_valid  out  1  y holds data from an accepted channel
- err  out  1  one-cycle pulse for a rejected select

## Operation
- Internal state:
  - ch, current channel, SEL_W bits
  - cnt, dwell counter, DWELL_W bits
  - armed, 1 bit
- Every cycle: y <= c[ch]; y_ch <= ch; y_valid <= armed.
- Select handshake, in both modes:
  - sel_valid=1 and sel<CHANNELS: ch <= sel, cnt <= 0, armed <= 1.
  - sel_valid=1 and sel≥CHANNELS (only possible when CHANNELS is not a power of 2): the select is rejected. ch and cnt are unchanged, and err=1 on the next cycle.
- Direct mode (scan_en=0):
  - ch changes only through the select handshake.
  - cnt is held at 0.
- Scan mode (scan_en=1):
  - First cycle that scan_en is sampled 1 after being 0: cnt <= 0, armed <= 1. ch is not changed.
  - Otherwise, if cnt == dwell: cnt <= 0 and ch <= (ch==CHANNELS-1) ? 0 : ch+1.
  - Otherwise: cnt <= cnt+1.
  - dwell=0: ch advances every cycle.
  - dwell is sampled live. If dwell is lowered below the current cnt, cnt counts up and wraps through 2^DWELL_W before matching. This is defined behaviour and is not treated as an error.
- Simultaneous events:
  - An accepted select takes priority over the scan advance in the same cycle.
  - A rejected select does not block the scan advance.
- Leaving scan mode: ch holds its last value; cnt <= 0.
- Changes on c propagate to y one cycle later with no other side effect.

## Timing
- Reset (n_reset low, asynchronous, any time including mid-scan): ch=0, cnt=0, armed=0, y=0, y_ch=0, y_valid=0, err=0.
- Reset release: the first active edge is the first edge at which n_reset is sampled high.
- Select latency, for an accepted select sampled at edge E:
  - ch updates at E.
  - y, y_ch and y_valid reflect it after E+1, a 2-edge latency.
- Data latency: a change on c at the selected channel appears on y after 1 edge.
- Scan period: each channel drives y for exactly dwell+1 consecutive cycles. A full rotation is CHANNELS*(dwell+1) cycles.
- err: exactly one cycle high per rejected select, aligned with the edge after sel_valid.
- No combinational path from any input to any output.

## Test plan
- Reset and direct select: assert n_reset=0, then release. y=0, y_ch=0, y_valid=0. With CHANNELS=4, WIDTH=4, c=16'hA5C3, select sel=2 with one sel_valid pulse. Two edges later: y=4'h5, y_ch=2, y_valid=1.
- Exhaustive direct sweep: for every c value 0..15 (WIDTH=1, CHANNELS=4), step sel 0→3. y must equal c[sel] two edges after each select.
- Scan with dwell=2, CHANNELS=4: y_ch sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0,…. With dwell=0, y_ch increments every cycle and wraps 3→0.
- Scan with a collision: sel_valid with sel=1 on the cycle cnt==dwell while ch=3. ch becomes 1, not 0, and the dwell restarts, giving a full dwell+1 cycles on channel 1.
- Rejected select with CHANNELS=5, SEL_W=3: sel=6 with sel_valid. err pulses for exactly 1 cycle and y_ch is unchanged. The same request in scan mode still advances the channel on schedule.
- Reset mid-scan: drop n_reset asynchronously between edges while ch=2 and cnt=1. All outputs go to 0 immediately. After release in scan mode, scanning restarts from channel 0.
